// File: rtl/h_kv_engine.sv
// Fully-associative key/value store with a sequential one-entry-per-cycle scan.
// Supports INSERT, FIND, ERASE and CLEAR commands, with valid/ready command and response channels.
module h_kv_engine #(
   parameter  int K_W       = 32,
   parameter  int V_W       = 32,
   parameter  int ENTRIES_N = 8,
   localparam int IDX_W     = $clog2(ENTRIES_N)
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             cmd_vld,
   input  logic [2:0]       cmd_opcode,
   input  logic [K_W-1:0]   cmd_key,
   input  logic [V_W-1:0]   cmd_val,
   output logic             cmd_rdy,
   output logic             rsp_vld,
   output logic [2:0]       rsp_status,
   output logic [V_W-1:0]   rsp_val,
   input  logic             rsp_rdy,
   output logic             busy,
   output logic [IDX_W:0]   occupancy
);

   // state  | meaning
   // IDLE   | ready for a command
   // SCAN   | compare entry idx against the latched key (INSERT/FIND/ERASE)
   // CLR    | invalidate entry idx
   // RSP    | response held until rsp_rdy
   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_CLR, S_RSP} state_t;

   localparam logic [2:0] OP_INSERT = 3'b000;
   localparam logic [2:0] OP_FIND   = 3'b100;
   localparam logic [2:0] OP_ERASE  = 3'b010;
   localparam logic [2:0] OP_CLEAR  = 3'b111;

   localparam logic [2:0] RSP_SUCCESS  = 3'b000;
   localparam logic [2:0] RSP_EXISTS   = 3'b010;
   localparam logic [2:0] RSP_FULL     = 3'b001;
   localparam logic [2:0] RSP_BADOP    = 3'b110;
   localparam logic [2:0] RSP_NOTFOUND = 3'b111;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES_N - 1);

   state_t             state_q, state_d;
   logic               run_q;
   logic [2:0]         op_q;
   logic [K_W-1:0]     key_q;
   logic [V_W-1:0]     val_q;
   logic [IDX_W-1:0]   idx_q;
   logic               free_found_q;
   logic [IDX_W-1:0]   free_idx_q;
   logic [ENTRIES_N-1:0] valid_q;
   logic [K_W-1:0]     key_tab [ENTRIES_N];
   logic [V_W-1:0]     val_tab [ENTRIES_N];
   logic [IDX_W:0]     occ_q;
   logic [2:0]         rsp_status_q;
   logic [V_W-1:0]     rsp_val_q;

   logic               accept, hit, last, cur_free, tab_we;
   logic [IDX_W-1:0]   tab_widx;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      accept   = cmd_vld && cmd_rdy;
      hit      = valid_q[idx_q] && (key_tab[idx_q] == key_q);
      last     = (idx_q == IDX_LAST);
      cur_free = !valid_q[idx_q];
      // An INSERT miss writes on the last compare; the final entry itself may be the free slot.
      tab_we   = (state_q == S_SCAN) && (op_q == OP_INSERT) && !hit && last
                 && (free_found_q || cur_free);
      tab_widx = free_found_q ? free_idx_q : idx_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (cmd_opcode == OP_INSERT || cmd_opcode == OP_FIND || cmd_opcode == OP_ERASE)
                  state_d = S_SCAN;
               else if (cmd_opcode == OP_CLEAR)
                  state_d = S_CLR;
               else
                  state_d = S_RSP;
            end
         end
         S_SCAN:  if (hit || last) state_d = S_RSP;
         S_CLR:   if (last) state_d = S_RSP;
         S_RSP:   if (rsp_rdy) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         run_q        <= 1'b0;
         op_q         <= '0;
         key_q        <= '0;
         val_q        <= '0;
         idx_q        <= '0;
         free_found_q <= 1'b0;
         free_idx_q   <= '0;
         valid_q      <= '0;
         occ_q        <= '0;
         rsp_status_q <= '0;
         rsp_val_q    <= '0;
      end else begin
         run_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  op_q         <= cmd_opcode;
                  key_q        <= cmd_key;
                  val_q        <= cmd_val;
                  idx_q        <= '0;
                  free_found_q <= 1'b0;
                  if (state_d == S_RSP) begin
                     rsp_status_q <= RSP_BADOP;
                     rsp_val_q    <= '0;
                  end
               end
            end
            S_SCAN: begin
               if (hit) begin
                  rsp_val_q    <= val_tab[idx_q];
                  rsp_status_q <= (op_q == OP_INSERT) ? RSP_EXISTS : RSP_SUCCESS;
                  if (op_q == OP_ERASE) begin
                     valid_q[idx_q] <= 1'b0;
                     occ_q          <= occ_q - 1'b1;
                  end
               end else if (last) begin
                  rsp_val_q <= '0;
                  if (op_q != OP_INSERT) begin
                     rsp_status_q <= RSP_NOTFOUND;
                  end else if (tab_we) begin
                     valid_q[tab_widx] <= 1'b1;
                     occ_q             <= occ_q + 1'b1;
                     rsp_status_q      <= RSP_SUCCESS;
                  end else begin
                     rsp_status_q <= RSP_FULL;
                  end
               end else begin
                  idx_q <= idx_q + 1'b1;
                  if (!free_found_q && cur_free) begin
                     free_found_q <= 1'b1;
                     free_idx_q   <= idx_q;
                  end
               end
            end
            S_CLR: begin
               valid_q[idx_q] <= 1'b0;
               if (valid_q[idx_q]) occ_q <= occ_q - 1'b1;
               if (last) begin
                  rsp_status_q <= RSP_SUCCESS;
                  rsp_val_q    <= '0;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (tab_we) begin
         key_tab[tab_widx] <= key_q;
         val_tab[tab_widx] <= val_q;
      end
   end

   assign cmd_rdy    = run_q && (state_q == S_IDLE);
   assign rsp_vld    = (state_q == S_RSP);
   assign busy       = (state_q != S_IDLE);
   assign rsp_status = rsp_status_q;
   assign rsp_val    = rsp_val_q;
   assign occupancy  = occ_q;

endmodule
